ram_row_serializer: RTL and testbench

- Reader end of the filtered-image RAM, complementing the filter that writes it.
- After a start pulse, reads ROWS words of WIDTH pixels (1 bit/pixel) from the RAM read port and emits them as a serial pixel stream with valid/ready handshake.
- Pixel order is row 0 first, MSB first within each word; the stream carries start-of-frame and end-of-line markers.
- Uses a one-word prefetch buffer so the stream has no bubbles between rows when the sink holds pix_ready high.

---
 rtl/img_pkg.sv | 19 +
 rtl/ram_row_serializer_prefetch.sv | 82 ++++++++
 rtl/ram_row_serializer.sv | 137 +++++++++++++
 tb/tb_ram_row_serializer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/img_pkg.sv
// Shared image geometry and serializer state encoding for the filtered-image
// RAM reader.
package img_pkg;

    localparam int IMG_WIDTH  = 64;
    localparam int IMG_ROWS   = 64;
    localparam int RAM_ADDR_W = 7;

    typedef logic [IMG_WIDTH-1:0] row_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        LOAD   = 3'd2,
        STREAM = 3'd3,
        DONE   = 3'd4
    } rs_state_t;

endpackage

// File: rtl/ram_row_serializer_prefetch.sv
// One-row prefetch buffer: owns the RAM read address and captures the next row
// while the serializer shifts out the current one.
module row_prefetch
    import img_pkg::*;
#(
    parameter int WIDTH  = IMG_WIDTH,
    parameter int ROWS   = IMG_ROWS,
    parameter int ADDR_W = RAM_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic              load,
    input  logic              consume,
    input  logic [WIDTH-1:0]  ram_rd_data,
    output logic [ADDR_W-1:0] ram_rd_addr,
    output logic [WIDTH-1:0]  next_row
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ROWS - 1);

    logic [ADDR_W-1:0] addr_r, nxt_addr_s;
    logic              issue_r, nxt_issue_s;
    logic              cap_r, nxt_cap_s;
    logic              pf_full_r, nxt_full_s;
    logic [WIDTH-1:0]  pf_buf_r, nxt_buf_s;

    // Address issue and capture: data returns the cycle after the address is driven.
    always_comb begin
        nxt_addr_s  = addr_r;
        nxt_issue_s = 1'b0;
        nxt_cap_s   = issue_r;
        nxt_buf_s   = pf_buf_r;
        nxt_full_s  = pf_full_r;
        if (cap_r) begin
            nxt_buf_s  = ram_rd_data;
            nxt_full_s = 1'b1;
        end else begin
            nxt_buf_s  = pf_buf_r;
        end
        if (frame_start) begin
            nxt_addr_s = {ADDR_W{1'b0}};
            nxt_cap_s  = 1'b0;
            nxt_full_s = 1'b0;
        end else if (load && (LAST_ADDR != {ADDR_W{1'b0}})) begin
            nxt_addr_s  = ADDR_W'(1);
            nxt_issue_s = 1'b1;
        end else if (consume) begin
            nxt_full_s = 1'b0;
            if (addr_r < LAST_ADDR) begin
                nxt_addr_s  = addr_r + ADDR_W'(1);
                nxt_issue_s = 1'b1;
            end else begin
                nxt_addr_s  = addr_r;
            end
        end else begin
            nxt_addr_s = addr_r;
        end
    end

    // Prefetch state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_r    <= {ADDR_W{1'b0}};
            issue_r   <= 1'b0;
            cap_r     <= 1'b0;
            pf_full_r <= 1'b0;
            pf_buf_r  <= {WIDTH{1'b0}};
        end else begin
            addr_r    <= nxt_addr_s;
            issue_r   <= nxt_issue_s;
            cap_r     <= nxt_cap_s;
            pf_full_r <= nxt_full_s;
            pf_buf_r  <= nxt_buf_s;
        end
    end

    // A capture landing on the same edge as the eol hand-over is forwarded directly.
    assign next_row    = pf_full_r ? pf_buf_r : ram_rd_data;
    assign ram_rd_addr = addr_r;

endmodule

// File: rtl/ram_row_serializer.sv
// Reads a frame of rows from the filtered-image RAM and streams it out one
// pixel per handshake, MSB first, with start-of-frame and end-of-line markers.
module ram_row_serializer
    import img_pkg::*;
#(
    parameter int WIDTH  = IMG_WIDTH,
    parameter int ROWS   = IMG_ROWS,
    parameter int ADDR_W = RAM_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ram_rd_addr,
    input  logic [WIDTH-1:0]  ram_rd_data,
    output logic              pix_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              pix_sof,
    output logic              pix_eol,
    output logic [ADDR_W-1:0] pix_row
);

    localparam int                BW       = $clog2(WIDTH);
    localparam logic [BW-1:0]     BIT_TOP  = BW'(WIDTH - 1);
    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(ROWS - 1);

    rs_state_t         state_r, nxt_state_s;
    logic [WIDTH-1:0]  shift_r, nxt_shift_s, next_row_s;
    logic [BW-1:0]     bit_cnt_r, nxt_bit_cnt_s;
    logic [ADDR_W-1:0] row_r, nxt_row_s;
    logic              busy_r, done_r, valid_r, sof_r, eol_r;
    logic              nxt_busy_s, nxt_valid_s;
    logic              frame_start_s, load_s, consume_s, xfer_s;

    assign xfer_s = valid_r & pix_ready;

    row_prefetch #(
        .WIDTH  (WIDTH),
        .ROWS   (ROWS),
        .ADDR_W (ADDR_W)
    ) u_prefetch (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start_s),
        .load        (load_s),
        .consume     (consume_s),
        .ram_rd_data (ram_rd_data),
        .ram_rd_addr (ram_rd_addr),
        .next_row    (next_row_s)
    );

    // Next-state and datapath decode; a stalled transfer leaves everything as is.
    always_comb begin
        nxt_state_s   = state_r;
        nxt_shift_s   = shift_r;
        nxt_bit_cnt_s = bit_cnt_r;
        nxt_row_s     = row_r;
        frame_start_s = 1'b0;
        load_s        = 1'b0;
        consume_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    nxt_state_s   = FETCH;
                    frame_start_s = 1'b1;
                end else begin
                    nxt_state_s   = IDLE;
                end
            end
            FETCH: nxt_state_s = LOAD;
            LOAD: begin
                nxt_shift_s   = ram_rd_data;
                nxt_bit_cnt_s = BIT_TOP;
                nxt_row_s     = {ADDR_W{1'b0}};
                load_s        = 1'b1;
                nxt_state_s   = STREAM;
            end
            STREAM: begin
                if (!xfer_s) begin
                    nxt_state_s = STREAM;
                end else if (bit_cnt_r != {BW{1'b0}}) begin
                    nxt_shift_s   = {shift_r[WIDTH-2:0], 1'b0};
                    nxt_bit_cnt_s = bit_cnt_r - BW'(1);
                end else if (row_r == LAST_ROW) begin
                    nxt_state_s = DONE;
                end else begin
                    nxt_shift_s   = next_row_s;
                    nxt_bit_cnt_s = BIT_TOP;
                    nxt_row_s     = row_r + ADDR_W'(1);
                    consume_s     = 1'b1;
                end
            end
            DONE:    nxt_state_s = IDLE;
            default: nxt_state_s = IDLE;
        endcase
        nxt_busy_s  = (nxt_state_s == FETCH) || (nxt_state_s == LOAD) ||
                      (nxt_state_s == STREAM);
        nxt_valid_s = (nxt_state_s == STREAM);
    end

    // State, datapath and registered stream flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= IDLE;
            shift_r   <= {WIDTH{1'b0}};
            bit_cnt_r <= {BW{1'b0}};
            row_r     <= {ADDR_W{1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            valid_r   <= 1'b0;
            sof_r     <= 1'b0;
            eol_r     <= 1'b0;
        end else begin
            state_r   <= nxt_state_s;
            shift_r   <= nxt_shift_s;
            bit_cnt_r <= nxt_bit_cnt_s;
            row_r     <= nxt_row_s;
            busy_r    <= nxt_busy_s;
            done_r    <= (nxt_state_s == DONE);
            valid_r   <= nxt_valid_s;
            sof_r     <= nxt_valid_s && (nxt_row_s == {ADDR_W{1'b0}}) &&
                         (nxt_bit_cnt_s == BIT_TOP);
            eol_r     <= nxt_valid_s && (nxt_bit_cnt_s == {BW{1'b0}});
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign pix_valid = valid_r;
    assign pix_sof   = sof_r;
    assign pix_eol   = eol_r;
    assign pix_row   = row_r;
    assign pix_data  = shift_r[WIDTH-1];

endmodule

// File: tb/tb_ram_row_serializer.sv
// Directed bench for ram_row_serializer: a pixel-index model of the frame checked
// every cycle, plus a one-row, 8-pixel build with a literal pixel sequence.
module tb_ram_row_serializer;

    localparam int W  = 64;
    localparam int R  = 64;
    localparam int AW = 7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start, pix_ready;
    logic          busy, done, pix_data, pix_valid, pix_sof, pix_eol;
    logic [AW-1:0] ram_rd_addr, pix_row;
    logic [W-1:0]  ram_q;

    logic          start8, ready8;
    logic          busy8, done8, data8, valid8, sof8, eol8;
    logic [AW-1:0] addr8, row8;
    logic [7:0]    ram8_q;

    ram_row_serializer dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_q),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_sof(pix_sof), .pix_eol(pix_eol), .pix_row(pix_row)
    );

    ram_row_serializer #(.WIDTH(8), .ROWS(1), .ADDR_W(AW)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .busy(busy8), .done(done8),
        .ram_rd_addr(addr8), .ram_rd_data(ram8_q),
        .pix_data(data8), .pix_valid(valid8), .pix_ready(ready8),
        .pix_sof(sof8), .pix_eol(eol8), .pix_row(row8)
    );

    function automatic logic [W-1:0] row_val(input int r);
        logic [W-1:0] p;
        p = {32{2'b10}};
        return p ^ W'(r);
    endfunction

    // Synchronous-read RAM models.
    always @(posedge clk) ram_q  <= row_val(int'(ram_rd_addr));
    always @(posedge clk) ram8_q <= 8'hA5;

    int vectors = 0, miscompares = 0;
    int tmo_cnt = 0, tmo_seen = 0;
    int m_mode = 0, m_pre = 0, m_idx = 0, frames_done = 0, frame_no = 0;
    int sof_cnt = 0, eol_cnt = 0, bpos = 0;
    int m8_mode = 0, m8_pre = 0, m8_idx = 0;
    logic [W-1:0] obs = '0, rv;
    logic [7:0]   pat8 = 8'hA5;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model modes: 0 idle, 1 fetch/load latency, 2 streaming, 3 done cycle.
    always @(negedge clk) begin
        if (tmo_cnt != tmo_seen) begin
            chk("wait_budget", 64'(tmo_cnt), 64'(tmo_seen));
            tmo_seen = tmo_cnt;
        end
        if (!rst) begin
            chk("rst_valid", 64'(pix_valid), 64'(0));
            chk("rst_busy",  64'(busy), 64'(0));
            chk("rst_done",  64'(done), 64'(0));
            chk("rst_addr",  64'(ram_rd_addr), 64'(0));
            chk("rst_row",   64'(pix_row), 64'(0));
            chk("rst_flags", 64'({pix_sof, pix_eol}), 64'(0));
            chk("rst_valid8", 64'({valid8, busy8, done8}), 64'(0));
            m_mode = 0; m_idx = 0; m8_mode = 0; m8_idx = 0;
        end else begin
            chk("busy",  64'(busy), 64'((m_mode == 1) || (m_mode == 2)));
            chk("done",  64'(done), 64'(m_mode == 3));
            chk("valid", 64'(pix_valid), 64'(m_mode == 2));
            chk("addr_range", 64'(ram_rd_addr <= AW'(R - 1)), 64'(1));
            case (m_mode)
                0: if (start) begin
                    m_mode = 1; m_pre = 2; m_idx = 0; sof_cnt = 0; eol_cnt = 0;
                end
                1: begin
                    m_pre--;
                    if (m_pre == 0) m_mode = 2;
                end
                2: begin
                    rv   = row_val(m_idx / W);
                    bpos = (W - 1) - (m_idx % W);
                    chk("pix_data", 64'(pix_data), 64'(rv[bpos]));
                    chk("pix_sof",  64'(pix_sof), 64'(m_idx == 0));
                    chk("pix_eol",  64'(pix_eol), 64'(bpos == 0));
                    chk("pix_row",  64'(pix_row), 64'(m_idx / W));
                    if (pix_ready) begin
                        if (pix_sof) sof_cnt++;
                        obs = {obs[W-2:0], pix_data};
                        if (pix_eol) begin
                            eol_cnt++;
                            if (pix_row != AW'(R - 1))
                                chk("pf_full_at_eol", 64'(dut.u_prefetch.pf_full_r), 64'(1));
                            if (frame_no == 0 && pix_row == AW'(0))
                                chk("row0_literal", obs, 64'hAAAA_AAAA_AAAA_AAAA);
                            if (frame_no == 0 && pix_row == AW'(10))
                                chk("row10_literal", obs, 64'hAAAA_AAAA_AAAA_AAA0);
                            if (frame_no == 0 && pix_row == AW'(63))
                                chk("row63_literal", obs, 64'hAAAA_AAAA_AAAA_AA95);
                        end
                        m_idx++;
                        if (m_idx == W * R) m_mode = 3;
                    end
                end
                3: begin
                    chk("sof_count", 64'(sof_cnt), 64'(1));
                    chk("eol_count", 64'(eol_cnt), 64'(R));
                    frames_done++; frame_no++; m_mode = 0;
                end
                default: m_mode = 0;
            endcase

            chk("b8_busy",  64'(busy8), 64'((m8_mode == 1) || (m8_mode == 2)));
            chk("b8_done",  64'(done8), 64'(m8_mode == 3));
            chk("b8_valid", 64'(valid8), 64'(m8_mode == 2));
            chk("b8_addr",  64'(addr8), 64'(0));
            case (m8_mode)
                0: if (start8) begin m8_mode = 1; m8_pre = 2; m8_idx = 0; end
                1: begin
                    m8_pre--;
                    if (m8_pre == 0) m8_mode = 2;
                end
                2: begin
                    chk("b8_data", 64'(data8), 64'(pat8[7 - m8_idx]));
                    chk("b8_sof",  64'(sof8), 64'(m8_idx == 0));
                    chk("b8_eol",  64'(eol8), 64'(m8_idx == 7));
                    chk("b8_row",  64'(row8), 64'(0));
                    if (ready8) begin
                        m8_idx++;
                        if (m8_idx == 8) m8_mode = 3;
                    end
                end
                3: m8_mode = 0;
                default: m8_mode = 0;
            endcase
        end
    end

    // pol: 0 ready high, 1 random ready, 2 restart at row 10 + stall at row 3 eol,
    // 3 reset at row 20 bit 5.
    task automatic run_frame(input int pol);
        int  base, row20, stall;
        bit  ok, stalled, restarted;
        base = frames_done; row20 = 0; stall = 0; ok = 0; stalled = 0; restarted = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 0; cyc < 20000; cyc++) begin
            case (pol)
                1: pix_ready = 1'($urandom_range(0, 1));
                2: begin
                    start = 1'b0;
                    if (stall > 0) begin
                        pix_ready = 1'b0; stall--;
                    end else if (!stalled && pix_valid && pix_row == AW'(3) && pix_eol) begin
                        pix_ready = 1'b0; stall = 199; stalled = 1;
                    end else begin
                        pix_ready = 1'b1;
                    end
                    if (!restarted && pix_valid && pix_row == AW'(10)) begin
                        start = 1'b1; restarted = 1;
                    end
                end
                3: if (pix_valid && pix_row == AW'(20)) begin
                    row20++;
                    if (row20 == 59) begin rst = 1'b0; ok = 1; end
                end
                default: pix_ready = 1'b1;
            endcase
            if (ok) break;
            @(posedge clk); #1;
            if (frames_done != base) begin ok = 1; break; end
        end
        if (!ok) tmo_cnt++;
        start = 1'b0;
        pix_ready = 1'b1;
        if (pol == 3) begin
            @(posedge clk); #1;
            @(posedge clk); #1;
            rst = 1'b1;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; pix_ready = 1'b1; start8 = 1'b0; ready8 = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        run_frame(0);
        run_frame(1);
        run_frame(2);
        run_frame(3);
        run_frame(0);
        repeat (3) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
